// File: rtl/xx6812_pkg.sv
// Shared timing constants and state encoding for the xx6812 LED protocol.
// The strip encoder and this decoder both take their timing from here.
package xx6812_pkg;

  localparam int BITS_PER_LED   = 24;
  localparam int HIGH_THRESHOLD = 6;
  localparam int MAX_HIGH       = 24;
  localparam int LATCH_CYCLES   = 600;

  localparam int LOW_CNT_W  = 10;
  localparam int HIGH_CNT_W = 5;
  localparam int BIT_CNT_W  = 5;
  localparam int WORD_CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } dec_state_t;

  // high_count excludes the rise cycle, so a pulse of N clocks arrives here as N-1.
  function automatic logic classify_bit(input logic [HIGH_CNT_W-1:0] high_count);
    return (high_count >= HIGH_CNT_W'(HIGH_THRESHOLD - 1));
  endfunction

endpackage

// File: rtl/decoder_xx6812_sync_edge_detect.sv
// Two-flop synchronizer plus a delay flop giving a clean level and rise/fall strobes.
// Generic enough to sit in front of a uart_rx as well.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronizer chain and edge-detect delay stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= async_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign sync_level = s2_r;
  assign rise       = s2_r & ~s3_r;
  assign fall       = ~s2_r & s3_r;

endmodule

// File: rtl/decoder_xx6812.sv
// One-wire xx6812 LED stream receiver: pulse-width bit decode, 24-bit GRB words, latch detection.
// Optional daisy-chain output serial_forward is enabled by defining XX6812_DECODER_FORWARD_EN.
module decoder_xx6812
  import xx6812_pkg::*;
(
  input  logic        clock_12mhz,
  input  logic        reset,
  input  logic        serial_data_in,
  output logic [23:0] parallel_data_out,
  output logic        data_valid,
  output logic [7:0]  led_index,
  output logic        frame_done,
  output logic        error
`ifdef XX6812_DECODER_FORWARD_EN
  ,
  output logic        serial_forward
`endif
);

  logic s2_s;
  logic rise_s;
  logic fall_s;

  dec_state_t state_r;
  dec_state_t next_state_s;

  logic [LOW_CNT_W-1:0]    low_count_r;
  logic [HIGH_CNT_W-1:0]   high_count_r;
  logic [BIT_CNT_W-1:0]    bit_count_r;
  logic [WORD_CNT_W-1:0]   word_count_r;
  logic [BITS_PER_LED-1:0] shift_r;

  logic wait_done_s;
  logic stuck_s;
  logic latch_s;
  logic bit_val_s;
  logic word_done_s;

  sync_edge_detect u_sync (
    .clk        (clock_12mhz),
    .rst        (reset),
    .async_in   (serial_data_in),
    .sync_level (s2_s),
    .rise       (rise_s),
    .fall       (fall_s)
  );

  assign wait_done_s = (state_r == WAIT_LATCH) && !s2_s &&
                       (low_count_r == LOW_CNT_W'(LATCH_CYCLES - 1));
  // Error fires on the MAX_HIGH-th high clock: the rise cycle plus MAX_HIGH-1 counted cycles.
  assign stuck_s     = (state_r == HIGH) && s2_s &&
                       (high_count_r == HIGH_CNT_W'(MAX_HIGH - 2));
  assign latch_s     = (state_r == LOW) && !rise_s && !s2_s &&
                       (low_count_r == LOW_CNT_W'(LATCH_CYCLES - 1));
  assign bit_val_s   = classify_bit(high_count_r);
  assign word_done_s = (state_r == HIGH) && fall_s &&
                       (bit_count_r == BIT_CNT_W'(BITS_PER_LED - 1));

  // State register.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state_r <= WAIT_LATCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      WAIT_LATCH: begin
        if (wait_done_s) next_state_s = IDLE;
        else             next_state_s = WAIT_LATCH;
      end
      IDLE: begin
        if (rise_s) next_state_s = HIGH;
        else        next_state_s = IDLE;
      end
      HIGH: begin
        if (stuck_s)     next_state_s = WAIT_LATCH;
        else if (fall_s) next_state_s = LOW;
        else             next_state_s = HIGH;
      end
      LOW: begin
        if (rise_s)       next_state_s = HIGH;
        else if (latch_s) next_state_s = IDLE;
        else              next_state_s = LOW;
      end
      default: next_state_s = WAIT_LATCH;
    endcase
  end

  // Counters, shift register and registered output pulses.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      low_count_r       <= '0;
      high_count_r      <= '0;
      bit_count_r       <= '0;
      word_count_r      <= '0;
      shift_r           <= '0;
      parallel_data_out <= 24'h000000;
      led_index         <= 8'h00;
      data_valid        <= 1'b0;
      frame_done        <= 1'b0;
      error             <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state_r)
        WAIT_LATCH: begin
          if (s2_s)              low_count_r <= '0;
          else if (!wait_done_s) low_count_r <= low_count_r + LOW_CNT_W'(1);
          else                   low_count_r <= '0;
        end
        IDLE: begin
          if (rise_s) high_count_r <= '0;
        end
        HIGH: begin
          if (stuck_s) begin
            error        <= 1'b1;
            shift_r      <= '0;
            bit_count_r  <= '0;
            word_count_r <= '0;
            low_count_r  <= '0;
          end else if (fall_s) begin
            low_count_r <= '0;
            if (word_done_s) begin
              parallel_data_out <= {shift_r[BITS_PER_LED-2:0], bit_val_s};
              data_valid        <= 1'b1;
              led_index         <= word_count_r;
              word_count_r      <= word_count_r + WORD_CNT_W'(1);
              bit_count_r       <= '0;
              shift_r           <= '0;
            end else begin
              shift_r     <= {shift_r[BITS_PER_LED-2:0], bit_val_s};
              bit_count_r <= bit_count_r + BIT_CNT_W'(1);
            end
          end else if (s2_s) begin
            high_count_r <= high_count_r + HIGH_CNT_W'(1);
          end
        end
        LOW: begin
          if (rise_s) begin
            high_count_r <= '0;
          end else if (latch_s) begin
            frame_done   <= 1'b1;
            word_count_r <= '0;
            if (bit_count_r != '0) begin
              error       <= 1'b1;
              shift_r     <= '0;
              bit_count_r <= '0;
            end
          end else begin
            low_count_r <= low_count_r + LOW_CNT_W'(1);
          end
        end
        default: begin
          low_count_r <= '0;
        end
      endcase
    end
  end

`ifdef XX6812_DECODER_FORWARD_EN
  logic fwd_en_r;

  // Forward gate opens after the first word of a frame and closes on latch or error.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      fwd_en_r       <= 1'b0;
      serial_forward <= 1'b0;
    end else begin
      if (latch_s || stuck_s) fwd_en_r <= 1'b0;
      else if (word_done_s)   fwd_en_r <= 1'b1;
      serial_forward <= s2_s & fwd_en_r;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_xx6812.sv
// Directed self-checking bench for decoder_xx6812.
// Define XX6812_DECODER_FORWARD_EN to also exercise serial_forward.
module tb_decoder_xx6812;

  logic        clock_12mhz = 1'b0;
  logic        reset;
  logic        serial_data_in;
  logic [23:0] parallel_data_out;
  logic        data_valid;
  logic [7:0]  led_index;
  logic        frame_done;
  logic        error;
`ifdef XX6812_DECODER_FORWARD_EN
  logic        serial_forward;
`endif

  int checks;
  int errors;

  logic [23:0] dv_data[$];
  logic [7:0]  dv_idx[$];
  int fd_cnt;
  int err_cnt;
  int fd_err_cnt;

  decoder_xx6812 dut (
    .clock_12mhz       (clock_12mhz),
    .reset             (reset),
    .serial_data_in    (serial_data_in),
    .parallel_data_out (parallel_data_out),
    .data_valid        (data_valid),
    .led_index         (led_index),
    .frame_done        (frame_done),
    .error             (error)
`ifdef XX6812_DECODER_FORWARD_EN
    ,
    .serial_forward    (serial_forward)
`endif
  );

  always #5 clock_12mhz = ~clock_12mhz;

  // Capture output pulses just after each active edge.
  always @(posedge clock_12mhz) begin
    #1;
    if (data_valid) begin
      dv_data.push_back(parallel_data_out);
      dv_idx.push_back(led_index);
    end
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
    if (frame_done && error) fd_err_cnt++;
  end

`ifdef XX6812_DECODER_FORWARD_EN
  int   fwd_phase = 0;
  int   fwd_w0_high = 0;
  int   fwd_w1_high = 0;
  int   fwd_bad = 0;
  logic din_d1 = 1'b0;
  logic din_d2 = 1'b0;

  // serial_forward should equal the pin as sampled two active edges earlier.
  always @(posedge clock_12mhz) begin
    #1;
    if (fwd_phase == 1 && serial_forward) fwd_w0_high++;
    if (fwd_phase == 2) begin
      if (serial_forward !== din_d2) fwd_bad++;
      if (serial_forward) fwd_w1_high++;
    end
    din_d2 = din_d1;
    din_d1 = serial_data_in;
  end
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [23:0] dat(input int i);
    if (i < dv_data.size()) return dv_data[i];
    return 24'hxxxxxx;
  endfunction

  function automatic logic [7:0] idx(input int i);
    if (i < dv_idx.size()) return dv_idx[i];
    return 8'hxx;
  endfunction

  task automatic clear_mon();
    dv_data.delete();
    dv_idx.delete();
    fd_cnt = 0;
    err_cnt = 0;
    fd_err_cnt = 0;
  endtask

  task automatic drive(input logic v, input int n);
    serial_data_in = v;
    repeat (n) @(negedge clock_12mhz);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin drive(1'b1, 8); drive(1'b0, 8); end
    else   begin drive(1'b1, 4); drive(1'b0, 12); end
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_fast_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      drive(1'b1, w[i] ? 8 : 4);
      drive(1'b0, 2);
    end
  endtask

  task automatic latch_gap();
    drive(1'b0, 700);
  endtask

  task automatic test_reset();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", error); end
    checks++; if (parallel_data_out !== 24'h000000) begin errors++; $display("FAIL reset_data: got %h expected 000000", parallel_data_out); end
    checks++; if (led_index !== 8'h00) begin errors++; $display("FAIL reset_idx: got %h expected 00", led_index); end
  endtask

  task automatic test_single_word();
    clear_mon();
    drive(1'b0, 610);
    send_word(24'hA5C3F0);
    latch_gap();
    checks++; if (dv_data.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", dv_data.size()); end
    checks++; if (dat(0) !== 24'hA5C3F0) begin errors++; $display("FAIL single_data: got %h expected a5c3f0", dat(0)); end
    checks++; if (idx(0) !== 8'd0) begin errors++; $display("FAIL single_idx: got %0d expected 0", idx(0)); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL single_fd: got %0d expected 1", fd_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_three_words();
    logic [23:0] exp_w[3];
    exp_w[0] = 24'h000001; exp_w[1] = 24'hFFFFFF; exp_w[2] = 24'h800000;
    clear_mon();
    for (int i = 0; i < 3; i++) send_word(exp_w[i]);
    latch_gap();
    checks++; if (dv_data.size() !== 3) begin errors++; $display("FAIL three_count: got %0d expected 3", dv_data.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (dat(i) !== exp_w[i]) begin errors++; $display("FAIL three_data%0d: got %h expected %h", i, dat(i), exp_w[i]); end
      checks++; if (idx(i) !== 8'(i)) begin errors++; $display("FAIL three_idx%0d: got %0d expected %0d", i, idx(i), i); end
    end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL three_fd: got %0d expected 1", fd_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL three_err: got %0d expected 0", err_cnt); end
    checks++; if (led_index !== 8'd2) begin errors++; $display("FAIL hold_idx: got %0d expected 2", led_index); end
    checks++; if (parallel_data_out !== 24'h800000) begin errors++; $display("FAIL hold_data: got %h expected 800000", parallel_data_out); end
    clear_mon();
    send_word(24'h123456);
    latch_gap();
    checks++; if (dat(0) !== 24'h123456) begin errors++; $display("FAIL frame2_data: got %h expected 123456", dat(0)); end
    checks++; if (idx(0) !== 8'd0) begin errors++; $display("FAIL frame2_idx: got %0d expected 0", idx(0)); end
  endtask

  task automatic test_threshold();
    clear_mon();
    drive(1'b1, 5);  drive(1'b0, 11);
    drive(1'b1, 6);  drive(1'b0, 10);
    drive(1'b1, 23); drive(1'b0, 4);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    send_bit(1'b1);
    latch_gap();
    checks++; if (dat(0) !== 24'h600001) begin errors++; $display("FAIL threshold_data: got %h expected 600001", dat(0)); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL threshold_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_stuck();
    clear_mon();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    drive(1'b1, 30);
    drive(1'b0, 610);
    send_word(24'h3C3C3C);
    latch_gap();
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stuck_err: got %0d expected 1", err_cnt); end
    checks++; if (dv_data.size() !== 1) begin errors++; $display("FAIL stuck_count: got %0d expected 1", dv_data.size()); end
    checks++; if (dat(0) !== 24'h3C3C3C) begin errors++; $display("FAIL stuck_data: got %h expected 3c3c3c", dat(0)); end
    checks++; if (idx(0) !== 8'd0) begin errors++; $display("FAIL stuck_idx: got %0d expected 0", idx(0)); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL stuck_fd: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_partial_latch();
    clear_mon();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    latch_gap();
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL partial_fd: got %0d expected 1", fd_cnt); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL partial_err: got %0d expected 1", err_cnt); end
    checks++; if (fd_err_cnt !== 1) begin errors++; $display("FAIL partial_same_cycle: got %0d expected 1", fd_err_cnt); end
    checks++; if (dv_data.size() !== 0) begin errors++; $display("FAIL partial_dv: got %0d expected 0", dv_data.size()); end
  endtask

  task automatic test_latch_boundary();
    logic [23:0] w;
    w = 24'hF80000;
    clear_mon();
    for (int i = 23; i >= 0; i--) begin
      if (i == 18) begin drive(1'b1, 4); drive(1'b0, 600); end
      else send_bit(w[i]);
    end
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL boundary600_fd: got %0d expected 0", fd_cnt); end
    latch_gap();
    checks++; if (dat(0) !== 24'hF80000) begin errors++; $display("FAIL boundary600_data: got %h expected f80000", dat(0)); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL boundary600_err: got %0d expected 0", err_cnt); end
    clear_mon();
    send_bit(1'b1);
    send_bit(1'b1);
    drive(1'b1, 8); drive(1'b0, 601);
    drive(1'b1, 8); drive(1'b0, 700);
    checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL boundary601_fd: got %0d expected 2", fd_cnt); end
    checks++; if (err_cnt !== 2) begin errors++; $display("FAIL boundary601_err: got %0d expected 2", err_cnt); end
    checks++; if (dv_data.size() !== 0) begin errors++; $display("FAIL boundary601_dv: got %0d expected 0", dv_data.size()); end
  endtask

  task automatic test_latency();
    clear_mon();
    for (int i = 0; i < 23; i++) send_bit(1'b0);
    drive(1'b1, 8);
    serial_data_in = 1'b0;
    @(negedge clock_12mhz);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: got %b expected 0", data_valid); end
    @(negedge clock_12mhz);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL latency_edge2: got %b expected 0", data_valid); end
    @(negedge clock_12mhz);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL latency_edge3: got %b expected 1", data_valid); end
    checks++; if (parallel_data_out !== 24'h000001) begin errors++; $display("FAIL latency_data: got %h expected 000001", parallel_data_out); end
    latch_gap();
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL latency_fd: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_wrap();
    clear_mon();
    for (int i = 0; i < 257; i++) send_fast_word((i == 256) ? 24'h00000F : 24'h000000);
    latch_gap();
    checks++; if (dv_data.size() !== 257) begin errors++; $display("FAIL wrap_count: got %0d expected 257", dv_data.size()); end
    checks++; if (idx(255) !== 8'd255) begin errors++; $display("FAIL wrap_idx255: got %0d expected 255", idx(255)); end
    checks++; if (idx(256) !== 8'd0) begin errors++; $display("FAIL wrap_idx256: got %0d expected 0", idx(256)); end
    checks++; if (dat(256) !== 24'h00000F) begin errors++; $display("FAIL wrap_data: got %h expected 00000f", dat(256)); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL wrap_err: got %0d expected 0", err_cnt); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL wrap_fd: got %0d expected 1", fd_cnt); end
  endtask

`ifdef XX6812_DECODER_FORWARD_EN
  task automatic test_forward();
    clear_mon();
    fwd_phase = 1;
    send_word(24'hA5A5A5);
    fwd_phase = 2;
    send_word(24'h5A5A5A);
    fwd_phase = 0;
    latch_gap();
    checks++; if (fwd_w0_high !== 0) begin errors++; $display("FAIL fwd_word0: got %0d high samples expected 0", fwd_w0_high); end
    checks++; if (fwd_bad !== 0) begin errors++; $display("FAIL fwd_mirror: got %0d mismatched samples expected 0", fwd_bad); end
    checks++; if (fwd_w1_high == 0) begin errors++; $display("FAIL fwd_active: got %0d high samples expected nonzero", fwd_w1_high); end
    checks++; if (serial_forward !== 1'b0) begin errors++; $display("FAIL fwd_after_latch: got %b expected 0", serial_forward); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    fd_cnt = 0;
    err_cnt = 0;
    fd_err_cnt = 0;
    serial_data_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock_12mhz);
    test_reset();
    reset = 1'b0;
    test_single_word();
    test_three_words();
    test_threshold();
    test_stuck();
    test_partial_latch();
    test_latch_boundary();
    test_latency();
    test_wrap();
`ifdef XX6812_DECODER_FORWARD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_xx6812.md
Name: decoder_xx6812

Overview:
- Receiver for the one-wire xx6812 LED protocol that the strip encoder produces.
- Samples the serial line on the 12 MHz system clock and classifies each bit by its high-pulse width.
- Assembles bits MSB-first into 24-bit GRB words and reports each word with its LED index; detects the latch gap as end of frame.
- Used for loopback self-test of the strip path and for capturing upstream pixel streams into memory through the write port.

Parameters:
- BITS_PER_LED, 24, bits per LED word.
- HIGH_THRESHOLD, 6, high-pulse length in clocks at or above which the bit is 1 (encoder: 0 = 4 clocks high, 1 = 8 clocks high).
- MAX_HIGH, 24, high-pulse length in clocks at which the line is declared stuck (error).
- LATCH_CYCLES, 600, continuous low clocks that form the latch/reset gap (50 us).

Ports:
- clock_12mhz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- serial_data_in  input  1  asynchronous protocol line.
- parallel_data_out  output  24  last completed word, MSB = first received bit.
- data_valid  output  1  one-cycle pulse: parallel_data_out/led_index are new.
- led_index  output  8  index of the word in parallel_data_out within the current frame.
- frame_done  output  1  one-cycle pulse on latch gap detection.
- error  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset: all outputs 0, shift register 0, bit count 0, word count 0, counters 0, state WAIT_LATCH. Reset mid-word discards the partial word; no pulses are emitted.
- Input passes through a 2-flop synchronizer (s2), with a third flop (s3) for edge detection. rise = s2 & ~s3; fall = ~s2 & s3.
- WAIT_LATCH: count clocks with s2 low; any high clears the count. On the cycle count reaches LATCH_CYCLES-1 with s2 low, go to IDLE. No pulses are emitted, so the decoder always aligns to a frame start.
- IDLE: on rise, clear high_count and go to HIGH.
- HIGH: high_count increments each cycle s2 is high (saturating).
  - If high_count reaches MAX_HIGH-1 while still high: error pulse, discard partial word, go to WAIT_LATCH.
  - On fall, with h = high cycles counted: bit = (h >= HIGH_THRESHOLD). Shift bit into the LSB and increment bit count. Clear low_count and go to LOW.
  - On the 24th bit: load parallel_data_out, pulse data_valid, set led_index = word count, increment word count (wraps 255->0, no error), and clear bit count.
- LOW: low_count increments.
  - rise: go to HIGH. This takes precedence over latch on the same cycle.
  - Latch: low_count reaches LATCH_CYCLES-1 with s2 low and no rise. Pulse frame_done and reset the word count to 0.
    - If bit count != 0, also pulse error in the same cycle and discard the partial word.
    - Go to IDLE.
- Latency: data_valid is asserted on the 3rd rising clock edge after the pin falls at the end of bit 24 (2 sync + 1 output register). frame_done follows the same registering.
- parallel_data_out and led_index hold their values until the next data_valid. Only frame_done clears the word count; it does not clear led_index.
- A frame with zero words (latch only) gives frame_done without data_valid.

Optional Feature:
- Macro: XX6812_DECODER_FORWARD_EN.
- Defined: adds output serial_forward (1 bit), giving WS2812-style daisy-chaining.
  - serial_forward = s2 once the first word of the current frame has completed; 0 before that.
  - It is cleared back to gating-off by frame_done, reset, or error.
- Undefined: port and logic absent; everything else is identical.

Decomposition:
- Shared package xx6812_pkg: BITS_PER_LED, encoder/decoder timing constants (HIGH_THRESHOLD, MAX_HIGH, LATCH_CYCLES), and the state encoding (WAIT_LATCH, IDLE, HIGH, LOW). The encoder then draws its timing from the same source.
- One natural sub-module: sync_edge_detect (2-flop synchronizer + s3 delay, rise/fall outputs), reusable for uart_rx.

Test Plan:
- Reset, then line held low for 600 clocks, then word 0xA5C3F0 (4/8-clock highs, 16-clock bit period), then 600 low -> one data_valid with data 0xA5C3F0 and led_index 0, then frame_done; error never asserted.
- Line low 600, then 3 words 0x000001, 0xFFFFFF, 0x800000, then latch -> three data_valid pulses with indices 0,1,2 and matching data; frame_done once. A second frame restarts at index 0.
- Threshold boundary: highs of 5 and 6 clocks -> decoded 0 and 1 respectively.
- Line high for 30 clocks mid-word -> error pulse, no data_valid. Decoding resumes only after a 600-clock low; the next valid word decodes correctly.
- 10 bits then latch -> frame_done and error in the same cycle, no data_valid. Rising edge exactly at low_count 599 -> treated as bit, no frame_done.
- 257 words in one frame -> led_index wraps to 0 on word 257, no error. With XX6812_DECODER_FORWARD_EN: serial_forward is 0 during word 0 and mirrors the input (3-clock delay) from word 1 on.
